// File: rtl/cube_pair_search.sv
// rtl/cube_pair_search.sv - two-pointer search for a^3 + b^3 == N (optional a^3 - b^3 == N under CUBE_DIFF_EN)
module cube_pair_search #(
    parameter int N_W = 32,
    parameter int A_W = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n_in,
`ifdef CUBE_DIFF_EN
    input  logic           mode,
`endif
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [A_W-1:0] a_out,
    output logic [A_W-1:0] b_out,
    output logic [15:0]    steps
);

    // Cubes of A_W-bit operands and their sums fit in 3*A_W+1 bits.
    localparam int C_W = 3 * A_W + 1;
    localparam logic [A_W-1:0] A_MAX = '1;
    localparam logic [A_W-1:0] A_ONE = {{(A_W - 1){1'b0}}, 1'b1};

    if (3 * A_W < N_W) begin : g_width_check
        $error("cube_pair_search: 3*A_W must be >= N_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROOT,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N_W-1:0] n_r;
    logic [A_W-1:0] a_r;
    logic [A_W-1:0] b_r;
    logic           diff_r;
    logic           mode_in;

    logic           acc;
    logic           root_inc;
    logic           to_scan;
    logic           a_inc;
    logic           b_dec;
    logic           b_inc;
    logic           fin;
    logic           hit;

    logic [C_W-1:0] n_ext;
    logic [A_W:0]   bp1;
    logic [C_W-1:0] cube_bp1;
    logic [C_W-1:0] cube_a;
    logic [C_W-1:0] cube_b;
    logic [C_W-1:0] sum_ab;
    logic [C_W-1:0] dif_ab;

`ifdef CUBE_DIFF_EN
    assign mode_in = mode;
`else
    assign mode_in = 1'b0;
`endif

    function automatic logic [C_W-1:0] cube(input logic [A_W:0] x);
        logic [C_W-1:0] e;
        e = {{(C_W - A_W - 1){1'b0}}, x};
        return e * e * e;
    endfunction

    assign n_ext    = {{(C_W - N_W){1'b0}}, n_r};
    assign bp1      = {1'b0, b_r} + {{A_W{1'b0}}, 1'b1};
    assign cube_bp1 = cube(bp1);
    assign cube_a   = cube({1'b0, a_r});
    assign cube_b   = cube({1'b0, b_r});
    assign sum_ab   = cube_a + cube_b;
    assign dif_ab   = cube_a - cube_b;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle datapath actions.
    always_comb begin
        state_nxt = state;
        acc       = 1'b0;
        root_inc  = 1'b0;
        to_scan   = 1'b0;
        a_inc     = 1'b0;
        b_dec     = 1'b0;
        b_inc     = 1'b0;
        fin       = 1'b0;
        hit       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    acc       = 1'b1;
                    state_nxt = mode_in ? S_SCAN : S_ROOT;
                end
            end
            S_ROOT: begin
                if ((cube_bp1 <= n_ext) && (b_r != A_MAX)) begin
                    root_inc = 1'b1;
                end else begin
                    to_scan   = 1'b1;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (diff_r) begin
                    // a stays strictly above b; b climbs only while the gap exceeds one.
                    if (dif_ab == n_ext) begin
                        fin = 1'b1;
                        hit = 1'b1;
                    end else if (dif_ab < n_ext) begin
                        if (a_r == A_MAX) fin = 1'b1;
                        else              a_inc = 1'b1;
                    end else begin
                        if ((a_r - b_r) == A_ONE) fin = 1'b1;
                        else                      b_inc = 1'b1;
                    end
                end else begin
                    // Pointers converge from a=0 upward and b=root downward.
                    if (a_r > b_r) begin
                        fin = 1'b1;
                    end else if (sum_ab == n_ext) begin
                        fin = 1'b1;
                        hit = 1'b1;
                    end else if (sum_ab < n_ext) begin
                        if (a_r == A_MAX) fin = 1'b1;
                        else              a_inc = 1'b1;
                    end else begin
                        if (b_r == '0) fin = 1'b1;
                        else           b_dec = 1'b1;
                    end
                end
                if (fin) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand pointers, captured target, result and step counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            n_r    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= 1'b0;
            found  <= 1'b0;
            a_out  <= '0;
            b_out  <= '0;
            steps  <= '0;
        end else begin
            if (acc) begin
                n_r    <= n_in;
                b_r    <= '0;
                a_r    <= mode_in ? A_ONE : '0;
                diff_r <= mode_in;
                steps  <= '0;
                found  <= 1'b0;
                a_out  <= '0;
                b_out  <= '0;
            end
            if (root_inc) b_r <= b_r + A_ONE;
            if (to_scan)  a_r <= '0;
            if (a_inc)    a_r <= a_r + A_ONE;
            if (b_dec)    b_r <= b_r - A_ONE;
            if (b_inc)    b_r <= b_r + A_ONE;
            if (fin) begin
                found <= hit;
                a_out <= hit ? a_r : '0;
                b_out <= hit ? b_r : '0;
            end
            if (((state == S_ROOT) || (state == S_SCAN)) && (steps != 16'hFFFF)) begin
                steps <= steps + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cube_pair_search.sv
// tb/tb_cube_pair_search.sv - randomized self-checking bench for cube_pair_search
module tb_cube_pair_search;

    localparam int     N_W  = 32;
    localparam int     A_W  = 11;
    localparam longint AMAX = 2047;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [N_W-1:0] n_in  = '0;
`ifdef CUBE_DIFF_EN
    logic           mode  = 1'b0;
`endif
    logic           busy;
    logic           done;
    logic           found;
    logic [A_W-1:0] a_out;
    logic [A_W-1:0] b_out;
    logic [15:0]    steps;

    cube_pair_search #(.N_W(N_W), .A_W(A_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .n_in  (n_in),
`ifdef CUBE_DIFF_EN
        .mode  (mode),
`endif
        .busy  (busy),
        .done  (done),
        .found (found),
        .a_out (a_out),
        .b_out (b_out),
        .steps (steps)
    );

    always #5 clk = ~clk;

    int     total     = 0;
    int     bad       = 0;
    int     issued    = 0;
    int     done_seen = 0;
    bit     prev_done = 0;
    bit     e_found;
    longint e_a;
    longint e_b;
    int     e_steps;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: root phase walks b up to floor(cbrt(N)) clamped, then the
    // two pointers meet; difference mode climbs a and b from (1,0).
    function automatic void model(input longint n, input bit diff, output bit f,
                                  output longint ra, output longint rb, output int st);
        longint a, b, s;
        bit     fin;
        longint cnt;
        f = 0; fin = 0; cnt = 0; a = 0; b = 0;
        if (!diff) begin
            while (b < AMAX && (b + 1) * (b + 1) * (b + 1) <= n) b++;
            cnt = b + 1;
            while (!fin) begin
                cnt++;
                s = a * a * a + b * b * b;
                if (a > b) fin = 1;
                else if (s == n) begin f = 1; fin = 1; end
                else if (s < n) begin if (a == AMAX) fin = 1; else a++; end
                else begin if (b == 0) fin = 1; else b--; end
            end
        end else begin
            a = 1;
            while (!fin) begin
                cnt++;
                s = a * a * a - b * b * b;
                if (s == n) begin f = 1; fin = 1; end
                else if (s < n) begin if (a == AMAX) fin = 1; else a++; end
                else begin if (a - b == 1) fin = 1; else b++; end
            end
        end
        ra = f ? a : 0;
        rb = f ? b : 0;
        st = (cnt > 65535) ? 65535 : int'(cnt);
    endfunction

    // Compare process: every done pulse is checked against the pending expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_done) begin
                check("done_single_cycle", done, 0);
                check("busy_after_done", busy, 0);
            end
            if (done) begin
                if (done_seen >= issued) begin
                    check("done_without_request", done, 0);
                end else begin
                    check("found", found, e_found);
                    check("a_out", a_out, e_a);
                    check("b_out", b_out, e_b);
                    check("steps", steps, e_steps);
                    check("busy_with_done", busy, 1);
                    done_seen++;
                end
            end
        end
        prev_done = done && reset;
    end

    task automatic wait_done();
        int k = 0;
        while (done_seen < issued && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("search_completes", done_seen, issued);
        if (done_seen != issued) begin
            reset = 0;
            @(negedge clk);
            issued = done_seen;
            reset = 1;
        end
    endtask

    task automatic run(input longint n, input bit m);
        @(negedge clk);
        model(n, m, e_found, e_a, e_b, e_steps);
        n_in = N_W'(n);
`ifdef CUBE_DIFF_EN
        mode = m;
`endif
        start = 1;
        issued++;
        @(negedge clk);
        start = 0;
        wait_done();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_a_out"}, a_out, 0);
        check({tag, "_b_out"}, b_out, 0);
        check({tag, "_steps"}, steps, 0);
    endtask

    initial begin
        bit     f;
        longint ma, mb;
        int     ms, base;

        // Pin the reference model against hand-worked cases.
        model(1729, 0, f, ma, mb, ms);
        check("model_1729_found", f, 1); check("model_1729_a", ma, 1);
        check("model_1729_b", mb, 12);   check("model_1729_steps", ms, 15);
        model(35, 0, f, ma, mb, ms);
        check("model_35_found", f, 1); check("model_35_a", ma, 2); check("model_35_b", mb, 3);
        model(4, 0, f, ma, mb, ms);
        check("model_4_found", f, 0); check("model_4_a", ma, 0); check("model_4_b", mb, 0);
        model(0, 0, f, ma, mb, ms);
        check("model_0_found", f, 1); check("model_0_steps", ms, 2);

        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1;

        run(1729, 0);
        run(35, 0);
        run(4, 0);
        run(0, 0);
        run(64'hFFFF_FFFF, 0);

        // start pulsed during SCAN must be ignored.
        @(negedge clk);
        model(1729, 0, e_found, e_a, e_b, e_steps);
        n_in = 1729; start = 1; issued++;
        @(negedge clk);
        start = 0;
        repeat (13) @(negedge clk);
        n_in = 35; start = 1;
        @(negedge clk);
        start = 0;
        wait_done();

        // start held through DONE exit: only the first request is accepted.
        @(negedge clk);
        model(0, 0, e_found, e_a, e_b, e_steps);
        base = done_seen;
        n_in = 0; start = 1; issued++;
        repeat (4) @(negedge clk);
        start = 0;
        repeat (20) @(negedge clk);
        check("held_start_single_done", done_seen - base, 1);
        if (done_seen != issued) issued = done_seen;

        // Reset during ROOT aborts silently.
        @(negedge clk);
        n_in = 1729; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        check("abort_busy_before_reset", busy, 1);
        reset = 0;
        @(negedge clk);
        reset = 1;
        check_zero("abort");
        base = done_seen;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", done_seen - base, 0);

        for (int i = 0; i < 5; i++) run(longint'($urandom()), 0);
        for (int i = 0; i < 20; i++) run(longint'($urandom_range(0, 1 << 20)), 0);
        for (int i = 0; i < 15; i++) begin
            longint a, b;
            a = longint'($urandom_range(0, 300));
            b = longint'($urandom_range(0, 300));
            if (a > b) run(b * b * b + a * a * a, 0);
            else       run(a * a * a + b * b * b, 0);
        end

`ifdef CUBE_DIFF_EN
        model(7, 1, f, ma, mb, ms);
        check("model_d7_found", f, 1); check("model_d7_a", ma, 2); check("model_d7_b", mb, 1);
        run(7, 1);
        run(6, 1);
        run(0, 1);
        for (int i = 0; i < 10; i++) run(longint'($urandom_range(0, 100000)), 1);
        run(1729, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
